// File: rtl/event_flash_driver.sv
// Stretches short event pulses into LED flashes with a fixed on-time and off-gap,
// queueing events that arrive mid-flash in a saturating counter.
module event_flash_driver #(
   parameter int ON_CLKS  = 100,
   parameter int OFF_CLKS = 100,
   parameter int PEND_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PULSE,
   output logic              LED,
   output logic              BUSY,
   output logic [PEND_W-1:0] PENDING,
   output logic              OVERFLOW
);

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

   localparam logic [15:0]       ON_LAST  = 16'(ON_CLKS - 1);
   localparam logic [15:0]       OFF_LAST = 16'(OFF_CLKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              prev_q;
   logic              evt, off_done, deq, enq;

   assign evt      = PULSE & ~prev_q;
   assign off_done = (state_q == ST_OFF) && (cnt_q == OFF_LAST);
   assign deq      = off_done && (pend_q != '0);
   // An event at the end of the off-gap with an empty queue starts the next flash directly.
   assign enq      = evt && (state_q != ST_IDLE) && !(off_done && (pend_q == '0));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         prev_q  <= PULSE;
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (evt) state_d = ST_ON;
         ST_ON:   if (cnt_q == ON_LAST) state_d = ST_OFF;
         ST_OFF:  if (off_done) state_d = ((pend_q != '0) || evt) ? ST_ON : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      cnt_d = cnt_q + 16'd1;
      if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (enq && !deq) begin
         if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
         else                    ovf_d  = 1'b1;
      end else if (deq && !enq) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_comb begin
      LED      = (state_q == ST_ON);
      BUSY     = (state_q != ST_IDLE);
      PENDING  = pend_q;
      OVERFLOW = ovf_q;
   end

endmodule
